// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer and load-use hazard control for the 5-stage pipeline.
// Optional: PIPELINE_SEQ_STALL_COUNT_EN adds a saturating stall-cycle counter.
module pipeline_sequencer #(
  parameter int NB_ADDR      = 5,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic               i_step,
  input  logic               i_clear,
  input  logic               i_stop,
  input  logic [NB_ADDR-1:0] i_id_rs,
  input  logic [NB_ADDR-1:0] i_id_rt,
  input  logic               i_ex_memRead,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  input  logic               i_jump,
  output logic               o_halt,
  output logic               o_stall,
  output logic               o_pc_we,
  output logic               o_ifid_we,
  output logic               o_flush,
  output logic [2:0]         o_state,
  output logic               o_done,
  output logic [NB_CNT-1:0]  o_cycle_count
`ifdef PIPELINE_SEQ_STALL_COUNT_EN
  ,
  output logic [NB_CNT-1:0]  o_stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int NB_DRN = $clog2(DRAIN_CYCLES + 1);
  localparam logic [NB_DRN-1:0] DRN_LOAD =
    NB_DRN'(DRAIN_CYCLES - 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = '1;

  state_t              state;
  logic                step_go;
  logic [NB_DRN-1:0]   drain_cnt;
  logic [NB_CNT-1:0]   cycle_cnt;
  logic                adv;
  logic                hazard;
  logic                stall;
  logic                stop_ok;
  logic                launch;

  assign adv = (state == S_RUN) | (state == S_DRAIN)
             | ((state == S_STEP) & step_go);

  assign hazard = i_ex_memRead & (i_ex_rt != '0)
                & ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));

  assign stall   = adv & hazard;
  assign stop_ok = adv & i_stop & ~stall;
  assign launch  = (state == S_IDLE) & i_start;

  assign o_halt        = ~adv;
  assign o_stall       = stall;
  assign o_pc_we       = adv & ~stall & (state != S_DRAIN);
  assign o_ifid_we     = adv & ~stall & (state != S_DRAIN);
  assign o_flush       = adv & i_jump & ~stall;
  assign o_state       = state;
  assign o_done        = (state == S_DONE);
  assign o_cycle_count = cycle_cnt;

  // Sequencer FSM: mode selection, single-step gating and drain countdown
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      step_go   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          step_go <= 1'b0;
          if (i_start)
            state <= i_mode ? S_STEP : S_RUN;
        end
        S_RUN: begin
          if (stop_ok) begin
            state     <= S_DRAIN;
            drain_cnt <= DRN_LOAD;
          end
        end
        S_STEP: begin
          if (step_go) begin
            step_go <= 1'b0;
            if (stop_ok) begin
              state     <= S_DRAIN;
              drain_cnt <= DRN_LOAD;
            end
          end else if (i_step) begin
            step_go <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0)
            state <= S_DONE;
          else
            drain_cnt <= drain_cnt - NB_DRN'(1);
        end
        S_DONE: begin
          if (i_clear)
            state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          step_go <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of advancing cycles, cleared on each launch
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cycle_cnt <= '0;
    else if (launch)
      cycle_cnt <= '0;
    else if (adv && cycle_cnt != CNT_MAX)
      cycle_cnt <= cycle_cnt + NB_CNT'(1);
  end

`ifdef PIPELINE_SEQ_STALL_COUNT_EN
  logic [NB_CNT-1:0] stall_cnt;

  assign o_stall_count = stall_cnt;

  // Saturating count of load-use bubble cycles, cleared on each launch
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      stall_cnt <= '0;
    else if (launch)
      stall_cnt <= '0;
    else if (stall && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + NB_CNT'(1);
  end
`else
  // Default build carries no stall counter.
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_sequencer;

  localparam int NB_ADDR = 5;
  localparam int NB_CNT  = 6;
  localparam int DRAIN   = 4;
  localparam longint CMAX = (64'd1 << NB_CNT) - 1;

  logic               clk;
  logic               rst_n;
  logic               start, mode, step, clear, stop;
  logic [NB_ADDR-1:0] id_rs, id_rt, ex_rt;
  logic               ex_mem_read, jump;
  logic               halt, stall, pc_we, ifid_we, flush, done;
  logic [2:0]         state;
  logic [NB_CNT-1:0]  cycle_count;
`ifdef PIPELINE_SEQ_STALL_COUNT_EN
  logic [NB_CNT-1:0]  stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int adv_seen;

  // model: phase 0 idle,1 run,2 step,3 drain,4 done
  int     m_phase;
  bit     m_go;
  int     m_left;
  longint m_cnt;
  longint m_stc;

  pipeline_sequencer #(
    .NB_ADDR(NB_ADDR),
    .NB_CNT(NB_CNT),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_mode(mode),
    .i_step(step),
    .i_clear(clear),
    .i_stop(stop),
    .i_id_rs(id_rs),
    .i_id_rt(id_rt),
    .i_ex_memRead(ex_mem_read),
    .i_ex_rt(ex_rt),
    .i_jump(jump),
    .o_halt(halt),
    .o_stall(stall),
    .o_pc_we(pc_we),
    .o_ifid_we(ifid_we),
    .o_flush(flush),
    .o_state(state),
    .o_done(done),
    .o_cycle_count(cycle_count)
`ifdef PIPELINE_SEQ_STALL_COUNT_EN
    ,
    .o_stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_adv();
    return m_phase == 1 || m_phase == 3 || (m_phase == 2 && m_go);
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = ex_mem_read && ex_rt != 0
      && (ex_rt == id_rs || ex_rt == id_rt);
    return m_adv() && hz;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_go    = 0;
    m_left  = 0;
    m_cnt   = 0;
    m_stc   = 0;
  endtask

  task automatic model_step();
    bit a, s, fire;
    a    = m_adv();
    s    = m_stall();
    fire = a && stop && !s;
    if (a) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    if (s) m_stc = (m_stc == CMAX) ? CMAX : m_stc + 1;
    if (m_phase == 0) begin
      if (start) begin
        m_phase = mode ? 2 : 1;
        m_cnt   = 0;
        m_stc   = 0;
        m_go    = 0;
      end
    end else if (m_phase == 1) begin
      if (fire) begin
        m_phase = 3;
        m_left  = DRAIN;
      end
    end else if (m_phase == 2) begin
      if (m_go) begin
        m_go = 0;
        if (fire) begin
          m_phase = 3;
          m_left  = DRAIN;
        end
      end else if (step) begin
        m_go = 1;
      end
    end else if (m_phase == 3) begin
      m_left--;
      if (m_left == 0) m_phase = 4;
    end else begin
      if (clear) m_phase = 0;
    end
  endtask

  task automatic compare_all();
    bit a, s;
    a = m_adv();
    s = m_stall();
    chk("halt", halt, !a);
    chk("stall", stall, s);
    chk("pc_we", pc_we, a && !s && m_phase != 3);
    chk("ifid_we", ifid_we, a && !s && m_phase != 3);
    chk("flush", flush, a && jump && !s);
    chk("state", state, m_phase);
    chk("done", done, m_phase == 4);
    chk("cycle_count", cycle_count, m_cnt);
`ifdef PIPELINE_SEQ_STALL_COUNT_EN
    chk("stall_count", stall_count, m_stc);
`endif
  endtask

  task automatic tick();
    #1;
    compare_all();
    if (halt == 1'b0) adv_seen++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    start = 0; mode = 0; step = 0; clear = 0; stop = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0;
    ex_mem_read = 0; jump = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic launch(input bit md);
    start = 1; mode = md;
    tick();
    start = 0; mode = 0;
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // idle after reset, no start
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("idle_halt", halt, 1);
      chk("idle_state", state, 0);
      chk("idle_pc_we", pc_we, 0);
      tick();
    end

    // continuous run with HALT seen at cycle 6
    do_reset();
    launch(0);
    for (int i = 1; i <= 5; i++) tick();
    stop = 1;
    tick();
    stop = 0;
    for (int i = 7; i <= 10; i++) begin
      chk("run_drain_state", state, 3);
      tick();
    end
    chk("run_done_state", state, 4);
    chk("run_done", done, 1);
    chk("run_cycles", cycle_count, 10);
    clear = 1;
    tick();
    clear = 0;
    chk("run_cleared", state, 0);

    // single step: three pulses five cycles apart
    do_reset();
    launch(1);
    adv_seen = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1;
      tick();
      step = 0;
      for (int i = 0; i < 4; i++) tick();
    end
    chk("step_windows", adv_seen, 3);
    chk("step_cycles", cycle_count, 3);

    // load-use hazard versus jump flush
    do_reset();
    launch(0);
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; jump = 1;
    #1;
    chk("haz_stall", stall, 1);
    chk("haz_pc_we", pc_we, 0);
    chk("haz_flush", flush, 0);
    tick();
    ex_rt = 0;
    #1;
    chk("r0_stall", stall, 0);
    tick();
    ex_mem_read = 0; ex_rt = 7; id_rs = 1;
    #1;
    chk("jmp_flush", flush, 1);
    chk("jmp_pc_we", pc_we, 1);
    tick();
    quiet();

    // asynchronous reset in the middle of DRAIN
    do_reset();
    launch(0);
    ex_mem_read = 1; ex_rt = 3; id_rt = 3;
    stop = 1;
    tick();
    quiet();
    tick();
    stop = 1;
    tick();
    stop = 0;
    tick();
    chk("mid_drain_state", state, 3);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_state", state, 0);
    chk("rst_halt", halt, 1);
    chk("rst_cycles", cycle_count, 0);
`ifdef PIPELINE_SEQ_STALL_COUNT_EN
    chk("rst_stall_cnt", stall_count, 0);
`endif
    #1;
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom_range(0, 5) == 0);
      mode        = $urandom_range(0, 1);
      step        = ($urandom_range(0, 3) == 0);
      clear       = ($urandom_range(0, 5) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      id_rs       = NB_ADDR'($urandom_range(0, 3));
      id_rt       = NB_ADDR'($urandom_range(0, 3));
      ex_rt       = NB_ADDR'($urandom_range(0, 3));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      jump        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
